// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles every handshake/bus signal around the memory port arbiter:
// the instruction-fetch requester port (i_*), the load/store requester port
// (d_*) and the physical memory port (pmem_*).
//
// Modports:
//   slave  - the arbiter's view: takes requests and memory responses, drives
//            requester responses and the physical memory command.
//   master - the environment's view (CPU requesters plus physical memory):
//            drives requests and memory responses, observes everything else.
//
// Signals:
//   i_read / i_addr                       instruction read request (level-held)
//   i_rdata / i_resp                      instruction read data / done pulse
//   d_read / d_write / d_addr / d_wdata / d_byte_enable   data request
//   d_rdata / d_resp                      data read data / done pulse
//   pmem_read / pmem_write / pmem_addr / pmem_wdata / pmem_byte_enable
//                                         physical memory command
//   pmem_rdata / pmem_resp                physical memory read data / done pulse
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Instruction-fetch requester
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  // Load/store requester
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_byte_enable;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  // Physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [DATA_WIDTH-1:0] pmem_wdata;
  logic [BE_WIDTH-1:0]   pmem_byte_enable;
  logic [DATA_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata, d_byte_enable,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata, d_byte_enable,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one physical memory port between the instruction-fetch
// requester (read-only) and the load/store requester (read/write with byte
// enables). A request seen while idle is granted on the next clock edge and
// its command is latched for the whole transaction; simultaneous requests are
// resolved by alternating priority, so neither side can starve.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: i_* / d_* requester ports and the
//          pmem_* physical memory port
//
// Timing: request in IDLE at cycle N -> pmem command from N+1; pmem_resp at
// cycle K -> requester resp at K (combinational) -> IDLE at K+1, so there is
// always at least one idle cycle between two physical transactions.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t                state_reg;
  grant_t                last_grant_reg;
  logic [ADDR_WIDTH-1:0] cmd_addr_reg;
  logic [DATA_WIDTH-1:0] cmd_wdata_reg;
  logic [BE_WIDTH-1:0]   cmd_be_reg;
  logic                  cmd_we_reg;
  logic                  pmem_read_reg;
  logic                  pmem_write_reg;

  logic i_req;
  logic d_req;
  logic grant_i;

  assign i_req = bus.i_read;
  // A simultaneous read and write from the data side is handled as a write.
  assign d_req = bus.d_read | bus.d_write;

  // The instruction side wins when it is alone, or on a tie when the data
  // side had the previous grant.
  assign grant_i = i_req & (~d_req | (last_grant_reg == GRANT_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_D;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= '0;
      cmd_be_reg     <= '0;
      cmd_we_reg     <= 1'b0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_i) begin
            state_reg      <= SERVE_I;
            last_grant_reg <= GRANT_I;
            cmd_addr_reg   <= bus.i_addr;
            cmd_wdata_reg  <= '0;
            cmd_be_reg     <= '1;
            cmd_we_reg     <= 1'b0;
            pmem_read_reg  <= 1'b1;
            pmem_write_reg <= 1'b0;
          end else if (d_req) begin
            state_reg      <= SERVE_D;
            last_grant_reg <= GRANT_D;
            cmd_addr_reg   <= bus.d_addr;
            cmd_wdata_reg  <= bus.d_wdata;
            cmd_be_reg     <= bus.d_byte_enable;
            cmd_we_reg     <= bus.d_write;
            pmem_read_reg  <= ~bus.d_write;
            pmem_write_reg <= bus.d_write;
          end
        end
        SERVE_I, SERVE_D: begin
          // The latched command is the only thing that matters here; the
          // requester may change or drop its inputs without effect. The cmd
          // registers are cleared on completion so pmem_* read as zero in IDLE.
          if (bus.pmem_resp) begin
            state_reg      <= IDLE;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_be_reg     <= '0;
            cmd_we_reg     <= 1'b0;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          cmd_addr_reg   <= '0;
          cmd_wdata_reg  <= '0;
          cmd_be_reg     <= '0;
          cmd_we_reg     <= 1'b0;
          pmem_read_reg  <= 1'b0;
          pmem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  // Physical command comes straight from registers only.
  assign bus.pmem_read        = pmem_read_reg;
  assign bus.pmem_write       = pmem_write_reg;
  assign bus.pmem_addr        = cmd_addr_reg;
  assign bus.pmem_wdata       = cmd_wdata_reg;
  assign bus.pmem_byte_enable = cmd_be_reg;

  // Completion is forwarded in the same cycle; a pmem_resp seen in IDLE
  // matches neither serving state and is dropped.
  assign bus.i_resp  = (state_reg == SERVE_I) & bus.pmem_resp;
  assign bus.d_resp  = (state_reg == SERVE_D) & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (current owner + latched command + grant history) predicts every output on
// every falling edge; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Memory responder controls
  int          mem_lat        = 2;   // 0 = random latency 1..4
  bit          mem_fixed      = 1'b0;
  logic [31:0] mem_fixed_data = 32'h0;
  bit          spurious_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no response within bound, expected a response at t=%0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_requests();
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_byte_enable = '0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_requests();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(input bit want_i, input string name, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      cycles++;
      if (want_i ? bus.i_resp : bus.d_resp) got = 1'b1;
    end
    if (!got) timeout_fail(name);
  endtask

  task automatic wait_any(input string name, output int who);
    who = 0;
    for (int k = 0; k < 30 && who == 0; k++) begin
      @(negedge clk);
      if (bus.i_resp) who = 1;
      else if (bus.d_resp) who = 2;
    end
    if (who == 0) timeout_fail(name);
  endtask

  // ---------------- physical memory responder ----------------
  initial begin : memory
    int cnt;
    int rand_tgt;
    int tgt;
    cnt = 0;
    rand_tgt = 2;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = mem_fixed ? mem_fixed_data : 32'($urandom);
      if (!rst_n) begin
        cnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        tgt = (mem_lat != 0) ? mem_lat : rand_tgt;
        if (cnt >= tgt) begin
          bus.pmem_resp = 1'b1;
          cnt = 0;
          rand_tgt = $urandom_range(1, 4);
        end
      end else begin
        cnt = 0;
        if (spurious_en && $urandom_range(0, 7) == 0) bus.pmem_resp = 1'b1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int          owner;   // 0 none, 1 instruction, 2 data
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          we;
  } txn_t;

  initial begin : model
    txn_t cur;
    int   grant_log[$];
    int   last;
    int   pick;
    bit   ireq;
    bit   dreq;
    logic exp_rd, exp_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    cur.owner = 0; cur.addr = '0; cur.wdata = '0; cur.be = '0; cur.we = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ctrl", 64'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}), 64'(0));
        check("rst_addr", 64'(bus.pmem_addr), 64'(0));
        check("rst_wdata_be", 64'({bus.pmem_wdata, bus.pmem_byte_enable}), 64'(0));
        cur.owner = 0;
        grant_log.delete();
        continue;
      end
      exp_rd   = (cur.owner == 1) || (cur.owner == 2 && !cur.we);
      exp_wr   = (cur.owner == 2) && cur.we;
      exp_addr = (cur.owner != 0) ? cur.addr : 32'h0;
      exp_be   = (cur.owner == 1) ? 4'hF : (cur.owner == 2) ? cur.be : 4'h0;
      check("cyc_pmem_read", 64'(bus.pmem_read), 64'(exp_rd));
      check("cyc_pmem_write", 64'(bus.pmem_write), 64'(exp_wr));
      check("cyc_pmem_addr", 64'(bus.pmem_addr), 64'(exp_addr));
      check("cyc_pmem_be", 64'(bus.pmem_byte_enable), 64'(exp_be));
      if (cur.owner != 1)
        check("cyc_pmem_wdata", 64'(bus.pmem_wdata), 64'((cur.owner == 2) ? cur.wdata : 32'h0));
      check("cyc_i_resp", 64'(bus.i_resp), 64'(cur.owner == 1 && bus.pmem_resp));
      check("cyc_d_resp", 64'(bus.d_resp), 64'(cur.owner == 2 && bus.pmem_resp));
      if (bus.i_resp) check("cyc_i_rdata", 64'(bus.i_rdata), 64'(bus.pmem_rdata));
      if (bus.d_resp) check("cyc_d_rdata", 64'(bus.d_rdata), 64'(bus.pmem_rdata));

      if (cur.owner != 0) begin
        if (bus.pmem_resp) begin
          $display("txn %s addr=0x%08h we=%0d be=0x%0h rdata=0x%08h t=%0t",
                   (cur.owner == 1) ? "I" : "D", cur.addr, cur.we, exp_be, bus.pmem_rdata, $time);
          cur.owner = 0;
        end
      end else begin
        // Alternating priority: on a tie, whoever did not get the last grant.
        last = (grant_log.size() == 0) ? 2 : grant_log[$];
        ireq = bus.i_read;
        dreq = bus.d_read || bus.d_write;
        if (ireq && dreq) pick = (last == 1) ? 2 : 1;
        else if (ireq)    pick = 1;
        else if (dreq)    pick = 2;
        else              pick = 0;
        if (pick == 1) begin
          cur.owner = 1; cur.addr = bus.i_addr; cur.wdata = '0; cur.be = 4'hF; cur.we = 1'b0;
          grant_log.push_back(1);
        end else if (pick == 2) begin
          cur.owner = 2; cur.addr = bus.d_addr; cur.wdata = bus.d_wdata;
          cur.be = bus.d_byte_enable; cur.we = bus.d_write;
          grant_log.push_back(2);
        end
        if (grant_log.size() > 8) void'(grant_log.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int cyc;
    int who;
    int exp_order[4];
    bit ir, dr;
    exp_order = '{1, 2, 1, 2};
    clear_requests();
    rst_n = 1'b0;

    // Reset state
    step();
    step();
    @(negedge clk);
    check("reset_pmem_read", 64'(bus.pmem_read), 64'(0));
    check("reset_resps", 64'({bus.i_resp, bus.d_resp}), 64'(0));
    step();
    rst_n = 1'b1;

    // Instruction read, memory answers three cycles after pmem_read rises
    mem_lat = 4; mem_fixed = 1'b1; mem_fixed_data = 32'h00A00093;
    bus.i_read = 1'b1; bus.i_addr = 32'h60;
    @(negedge clk);
    check("t1_no_cmd_same_cycle", 64'(bus.pmem_read), 64'(0));
    step();
    @(negedge clk);
    check("t1_pmem_read", 64'(bus.pmem_read), 64'(1));
    check("t1_pmem_addr", 64'(bus.pmem_addr), 64'(32'h60));
    wait_resp(1'b1, "t1_i_resp", cyc);
    check("t1_resp_cycle", 64'(cyc), 64'(3));
    check("t1_i_rdata", 64'(bus.i_rdata), 64'(32'h00A00093));
    step();
    bus.i_read = 1'b0;
    @(negedge clk);
    check("t1_read_low_after", 64'({bus.pmem_read, bus.i_resp}), 64'(0));
    mem_fixed = 1'b0;

    // First tie after reset goes to I, then D after one idle cycle
    do_reset();
    mem_lat = 2;
    bus.i_read = 1'b1; bus.i_addr = 32'h400;
    bus.d_read = 1'b1; bus.d_addr = 32'h800;
    wait_resp(1'b1, "t2_i_first", cyc);
    check("t2_i_cycle", 64'(cyc), 64'(3));
    check("t2_i_addr", 64'(bus.pmem_addr), 64'(32'h400));
    check("t2_no_d_resp", 64'(bus.d_resp), 64'(0));
    step();
    bus.i_read = 1'b0;
    @(negedge clk);
    check("t2_gap", 64'({bus.pmem_read, bus.pmem_write}), 64'(0));
    wait_resp(1'b0, "t2_d_second", cyc);
    check("t2_d_cycle", 64'(cyc), 64'(2));
    check("t2_d_addr", 64'(bus.pmem_addr), 64'(32'h800));
    step();
    bus.d_read = 1'b0;

    // Sustained contention: strict alternation, one idle cycle between
    bus.i_read = 1'b1; bus.i_addr = 32'h1000;
    bus.d_read = 1'b1; bus.d_addr = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      wait_any("t3_resp", who);
      check("t3_grant_order", 64'(who), 64'(exp_order[t]));
      check("t3_addr", 64'(bus.pmem_addr), 64'((who == 1) ? bus.i_addr : bus.d_addr));
      step();
      if (t == 3) begin
        bus.i_read = 1'b0; bus.d_read = 1'b0;
      end else if (who == 1) begin
        bus.i_addr = bus.i_addr + 32'd4;
      end else begin
        bus.d_addr = bus.d_addr + 32'd4;
      end
      @(negedge clk);
      check("t3_gap", 64'({bus.pmem_read, bus.pmem_write}), 64'(0));
    end

    // Byte store
    step();
    bus.d_write = 1'b1; bus.d_addr = 32'h104; bus.d_wdata = 32'hAB; bus.d_byte_enable = 4'b0001;
    wait_resp(1'b0, "t4_d_resp", cyc);
    check("t4_write_read", 64'({bus.pmem_write, bus.pmem_read}), 64'(2'b10));
    check("t4_addr", 64'(bus.pmem_addr), 64'(32'h104));
    check("t4_wdata", 64'(bus.pmem_wdata), 64'(32'hAB));
    check("t4_be", 64'(bus.pmem_byte_enable), 64'(4'b0001));
    check("t4_no_i_resp", 64'(bus.i_resp), 64'(0));
    step();
    bus.d_write = 1'b0; bus.d_wdata = '0; bus.d_byte_enable = '0;

    // Request changes and drops after grant
    mem_lat = 3;
    bus.d_read = 1'b1; bus.d_addr = 32'h200;
    step();
    bus.d_addr = 32'h300; bus.d_read = 1'b0;
    wait_resp(1'b0, "t5_d_resp", cyc);
    check("t5_addr_held", 64'(bus.pmem_addr), 64'(32'h200));
    step();
    @(negedge clk);
    check("t5_no_regrant", 64'(bus.pmem_read), 64'(0));

    // Asynchronous reset in the middle of an instruction read
    mem_lat = 8;
    step();
    bus.i_read = 1'b1; bus.i_addr = 32'h500;
    step();
    #1;
    check("t6_busy_before", 64'(bus.pmem_read), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 64'({bus.pmem_read, bus.pmem_write}), 64'(0));
    check("t6_async_addr", 64'(bus.pmem_addr), 64'(0));
    check("t6_no_i_resp", 64'(bus.i_resp), 64'(0));
    clear_requests();
    step();
    step();
    rst_n = 1'b1;
    mem_lat = 2;
    bus.i_read = 1'b1; bus.i_addr = 32'h600;
    bus.d_read = 1'b1; bus.d_addr = 32'h700;
    wait_resp(1'b1, "t6_tie_i", cyc);
    check("t6_i_addr", 64'(bus.pmem_addr), 64'(32'h600));
    step();
    bus.i_read = 1'b0;
    wait_resp(1'b0, "t6_then_d", cyc);
    check("t6_d_addr", 64'(bus.pmem_addr), 64'(32'h700));
    step();
    bus.d_read = 1'b0;

    // Randomized traffic checked by the model
    mem_lat = 0;
    spurious_en = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      ir = bus.i_resp;
      dr = bus.d_resp;
      step();
      if (it == 1500) begin
        #1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        continue;
      end
      if (bus.i_read && ir) begin
        bus.i_read = 1'($urandom_range(0, 1));
        bus.i_addr = 32'($urandom);
      end else if (!bus.i_read) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_read = 1'b1;
          bus.i_addr = 32'($urandom);
        end
      end else if ($urandom_range(0, 5) == 0) begin
        bus.i_addr = 32'($urandom);
      end
      if ((bus.d_read || bus.d_write) && dr) begin
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end else if (!(bus.d_read || bus.d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0, 3: begin bus.d_read = 1'b1; bus.d_write = 1'b0; end
            1:    begin bus.d_read = 1'b0; bus.d_write = 1'b1; end
            default: begin bus.d_read = 1'b1; bus.d_write = 1'b1; end
          endcase
          bus.d_addr = 32'($urandom);
          bus.d_wdata = 32'($urandom);
          bus.d_byte_enable = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 5) == 0) begin
        bus.d_addr = 32'($urandom);
        bus.d_wdata = 32'($urandom);
        bus.d_byte_enable = 4'($urandom_range(0, 15));
      end
    end

    clear_requests();
    spurious_en = 1'b0;
    repeat (8) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between two requesters: the instruction-fetch requester (read-only) and the load/store data requester (read/write with byte enables).
- Sits between the CPU control/datapath and physical memory.
- Each requester uses the same level-held read/write plus one-cycle response protocol that the CPU already uses toward memory.
- Commands are latched at grant, and ties are broken by alternating priority.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_read  in  1  instruction read request, held until i_resp
i_addr  in  ADDR_WIDTH  instruction address
i_rdata  out  DATA_WIDTH  instruction read data
i_resp  out  1  instruction transaction complete, one-cycle pulse
d_read  in  1  data read request, held until d_resp
d_write  in  1  data write request, held until d_resp
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  data write data
d_byte_enable  in  DATA_WIDTH/8  data byte enables
d_rdata  out  DATA_WIDTH  data read data
d_resp  out  1  data transaction complete, one-cycle pulse
pmem_read  out  1  physical memory read
pmem_write  out  1  physical memory write
pmem_addr  out  ADDR_WIDTH  physical address
pmem_wdata  out  DATA_WIDTH  physical write data
pmem_byte_enable  out  DATA_WIDTH/8  physical byte enables
pmem_rdata  in  DATA_WIDTH  physical read data
pmem_resp  in  1  physical transaction complete, one-cycle pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Registers: state, last_grant (I/D), cmd_addr, cmd_wdata, cmd_be, cmd_we.
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = D, all cmd registers = 0.
  - pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable = 0 immediately.
  - i_resp and d_resp = 0.
- IDLE, no request: stay in IDLE; all pmem_* outputs = 0.
- IDLE, only I requesting (i_read): go to SERVE_I.
  - Latch cmd_addr = i_addr, cmd_we = 0, cmd_be = all ones.
- IDLE, only D requesting (d_read or d_write): go to SERVE_D.
  - Latch d_addr, d_wdata, d_byte_enable.
  - Latch cmd_we = d_write.
- IDLE, both requesting: grant the requester not equal to last_grant.
- last_grant updates on every grant.
- d_read and d_write both high: treated as a write.
- Outputs are driven only from registers, with no combinational path from i_*/d_* to pmem_*:
  - pmem_read = (SERVE_I) or (SERVE_D and not cmd_we).
  - pmem_write = SERVE_D and cmd_we.
  - pmem_addr, pmem_wdata, pmem_byte_enable = cmd registers while serving, 0 in IDLE.
- Latched command holds for the whole transaction. Requester address/data changes, or a request dropping after grant, do not affect pmem_* and do not abort; the response is still returned.
- pmem_resp while serving:
  - i_resp (SERVE_I) or d_resp (SERVE_D) = 1 in the same cycle, combinationally.
  - Next state is IDLE.
- pmem_resp in IDLE is ignored; no resp is generated.
- i_rdata and d_rdata are driven by pmem_rdata unconditionally. They are valid only when the corresponding resp is high.
- Latency:
  - Request seen in IDLE at cycle N gives a pmem command at N+1.
  - pmem_resp at cycle K gives the requester resp at K.
  - IDLE at K+1.
  - Next pmem command no earlier than K+2. This guarantees at least one deasserted cycle between transactions.
- Starvation-free: with both requests held continuously, grants strictly alternate.
- Reset mid-transaction: transaction abandoned, no resp issued, pmem_* low asynchronously.

Test Plan:
- Instruction read:
  - Stimulus: reset, then i_read=1, i_addr=0x00000060; pmem_resp with pmem_rdata=0x00A00093 three cycles after pmem_read rises.
  - Response: pmem_read=1 with pmem_addr=0x60 from the cycle after request; i_resp single-cycle pulse with i_rdata=0x00A00093; pmem_read low the next cycle.
- First tie after reset:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Response: SERVE_I first (pmem_addr=i_addr); after i_resp and one IDLE cycle, SERVE_D with pmem_addr=d_addr.
- Sustained contention:
  - Stimulus: both requests held for 4 transactions with 1-cycle pmem_resp latency.
  - Response: grant order I, D, I, D; resps alternate; pmem_read low exactly one cycle between transactions.
- Byte store:
  - Stimulus: d_write=1, d_addr=0x104, d_wdata=0x000000AB, d_byte_enable=0001.
  - Response: pmem_write=1, pmem_read=0, pmem_addr=0x104, pmem_wdata=0xAB, pmem_byte_enable=0001; d_resp pulses with pmem_resp; i_resp stays 0.
- Request changes mid-transaction:
  - Stimulus: after SERVE_D grant, change d_addr from 0x200 to 0x300 and drop d_read.
  - Response: pmem_addr stays 0x200; d_resp still pulses on pmem_resp.
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 mid-cycle during SERVE_I.
  - Response: pmem_read falls without waiting for a clock edge; no i_resp; after release, IDLE, and a tie goes to I.
